// File: rtl/tinker_mem_responder.sv
// ----------------------------------------------------------------------------
// tinker_mem_responder
//   Memory-side responder for Tinker core fetch/load/store accesses.
//   Accepts one request at a time over a valid/ready handshake and answers
//   after LATENCY cycles. Byte-addressed, little-endian, MEM_BYTES deep.
//
// Parameters
//   MEM_BYTES  byte capacity, valid addresses 0..MEM_BYTES-1
//   LATENCY    cycles from request acceptance to rsp_valid (1..15)
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous, active-low reset
//   req_valid  request present            req_ready  responder idle, can accept
//   req_op     00 fetch32, 01 load64, 10 store64, 11 reserved
//   req_addr   byte address of lowest byte
//   req_wdata  store data, byte 0 in bits [7:0]
//   rsp_valid  response present           rsp_ready  initiator takes response
//   rsp_data   fetch {32'd0,instr}; load 64-bit word; store/error 0
//   rsp_err    out of range, reserved op, or misaligned (when checked)
//
// Configuration
//   TINKER_MEM_ALIGN_CHECK_EN  when defined, misaligned fetch (addr[1:0]!=0)
//   or load/store (addr[2:0]!=0) is rejected; otherwise unaligned in-range
//   accesses are byte-assembled.
// ----------------------------------------------------------------------------
module tinker_mem_responder #(
   parameter int unsigned MEM_BYTES = 524288,
   parameter int unsigned LATENCY   = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [1:0]  req_op,
   input  logic [63:0] req_addr,
   input  logic [63:0] req_wdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [63:0] rsp_data,
   output logic        rsp_err
);

   localparam int unsigned AW     = (MEM_BYTES > 1) ? $clog2(MEM_BYTES) : 1;
   localparam logic [3:0]  LAT_M1 = 4'(LATENCY - 1);

   typedef enum logic [1:0] {
      OP_FETCH = 2'b00,
      OP_LOAD  = 2'b01,
      OP_STORE = 2'b10,
      OP_RSVD  = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_BUSY,
      ST_RESP
   } state_e;

   state_e      state_q;
   logic [3:0]  cnt_q;
   op_e         op_q;
   logic [63:0] addr_q;
   logic [63:0] wdata_q;
   logic        req_ready_q;
   logic        rsp_valid_q;
   logic [63:0] rsp_data_q;
   logic        rsp_err_q;

   logic [7:0]  mem [MEM_BYTES];

   logic [64:0]   end_excl;
   logic          range_err;
   logic          align_err;
   logic          acc_err;
   logic          do_access;
   logic          do_store;
   logic [63:0]   rd_word;
   logic [AW-1:0] base_idx;
   logic [63:0]   rsp_data_d;
   logic          rsp_err_d;

   // Access decode on the latched request. The 65-bit end address catches
   // both out-of-range and 64-bit wraparound in one comparison.
   always_comb begin
      end_excl  = {1'b0, addr_q} + ((op_q == OP_FETCH) ? 65'd4 : 65'd8);
      range_err = (end_excl > 65'(MEM_BYTES));
`ifdef TINKER_MEM_ALIGN_CHECK_EN
      align_err = (op_q == OP_FETCH) ? (addr_q[1:0] != '0) : (addr_q[2:0] != '0);
`else
      align_err = 1'b0;
`endif
      acc_err   = range_err || align_err || (op_q == OP_RSVD);
      do_access = (state_q == ST_BUSY) && (cnt_q == '0);
      // Gated by reset so a store in flight is cancelled if reset is low at
      // the access edge.
      do_store  = do_access && (op_q == OP_STORE) && !acc_err && reset;
      base_idx  = addr_q[AW-1:0];

      rd_word = '0;
      for (int unsigned i = 0; i < 8; i++) begin
         rd_word[8*i +: 8] = mem[base_idx + AW'(i)];
      end

      rsp_err_d  = acc_err;
      rsp_data_d = '0;
      if (!acc_err) begin
         case (op_q)
            OP_FETCH: rsp_data_d = {32'd0, rd_word[31:0]};
            OP_LOAD:  rsp_data_d = rd_word;
            default:  rsp_data_d = '0;
         endcase
      end
   end

   // Memory array: not reset, contents survive reset.
   always_ff @(posedge clk) begin
      if (do_store) begin
         for (int unsigned i = 0; i < 8; i++) begin
            mem[base_idx + AW'(i)] <= wdata_q[8*i +: 8];
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         op_q        <= OP_FETCH;
         addr_q      <= '0;
         wdata_q     <= '0;
         req_ready_q <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= '0;
         rsp_err_q   <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (req_valid && req_ready_q) begin
                  op_q        <= op_e'(req_op);
                  addr_q      <= req_addr;
                  wdata_q     <= req_wdata;
                  cnt_q       <= LAT_M1;
                  req_ready_q <= 1'b0;
                  state_q     <= ST_BUSY;
               end else begin
                  req_ready_q <= 1'b1;
               end
            end
            ST_BUSY: begin
               if (cnt_q == '0) begin
                  rsp_data_q  <= rsp_data_d;
                  rsp_err_q   <= rsp_err_d;
                  rsp_valid_q <= 1'b1;
                  state_q     <= ST_RESP;
               end else begin
                  cnt_q <= cnt_q - 4'd1;
               end
            end
            ST_RESP: begin
               if (rsp_ready) begin
                  rsp_valid_q <= 1'b0;
                  req_ready_q <= 1'b1;
                  state_q     <= ST_IDLE;
               end
            end
            default: begin
               state_q     <= ST_IDLE;
               req_ready_q <= 1'b0;
               rsp_valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign req_ready = req_ready_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_data  = rsp_data_q;
   assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_tinker_mem_responder.sv
// ----------------------------------------------------------------------------
// tb_tinker_mem_responder
//   Four responder instances (LATENCY 2, 1, 3, 15) on a shared clock with
//   individual resets. A byte-level associative-array memory model supplies
//   all expected responses and latencies.
// ----------------------------------------------------------------------------
module tb_tinker_mem_responder;

   localparam int NI = 4;
   localparam longint unsigned MEMB = 524288;
   localparam logic [63:0] RB = 64'h1000;

   logic              clk;
   logic              rst_n     [NI];
   logic              req_valid [NI];
   logic              req_ready [NI];
   logic [1:0]        req_op    [NI];
   logic [63:0]       req_addr  [NI];
   logic [63:0]       req_wdata [NI];
   logic              rsp_valid [NI];
   logic              rsp_ready [NI];
   logic [63:0]       rsp_data  [NI];
   logic              rsp_err   [NI];

   int n_checks = 0;
   int n_errors = 0;

   logic [7:0] mdl [longint unsigned];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   for (genvar g = 0; g < NI; g++) begin : g_dut
      localparam int unsigned LAT = (g == 0) ? 2 : (g == 1) ? 1 : (g == 2) ? 3 : 15;
      tinker_mem_responder #(
         .MEM_BYTES(524288),
         .LATENCY  (LAT)
      ) u_dut (
         .clk      (clk),
         .reset    (rst_n[g]),
         .req_valid(req_valid[g]),
         .req_ready(req_ready[g]),
         .req_op   (req_op[g]),
         .req_addr (req_addr[g]),
         .req_wdata(req_wdata[g]),
         .rsp_valid(rsp_valid[g]),
         .rsp_ready(rsp_ready[g]),
         .rsp_data (rsp_data[g]),
         .rsp_err  (rsp_err[g])
      );
   end

   function automatic int lat_of(int k);
      case (k)
         0:       return 2;
         1:       return 1;
         2:       return 3;
         default: return 15;
      endcase
   endfunction

   task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
      end
   endtask

   function automatic longint unsigned key(int k, logic [63:0] a);
      return (64'(k) << 32) | a;
   endfunction

   function automatic logic [63:0] mdl_rd(int k, logic [63:0] a, int n);
      logic [63:0] v = '0;
      for (int i = 0; i < n; i++) begin
         if (mdl.exists(key(k, a + 64'(i)))) v[8*i +: 8] = mdl[key(k, a + 64'(i))];
      end
      return v;
   endfunction

   function automatic logic exp_err(logic [1:0] op, logic [63:0] a);
      longint unsigned n = (op == 2'b00) ? 4 : 8;
      if (op == 2'b11) return 1'b1;
      if (a > MEMB - n) return 1'b1;
`ifdef TINKER_MEM_ALIGN_CHECK_EN
      if (op == 2'b00 && a[1:0] != 2'b00) return 1'b1;
      if (op != 2'b00 && a[2:0] != 3'b000) return 1'b1;
`endif
      return 1'b0;
   endfunction

   task automatic wait_ready(int k, string tag);
      int w = 0;
      @(negedge clk);
      while (!req_ready[k] && w < 20) begin
         @(negedge clk);
         w++;
      end
      chk({tag, ":ready"}, 64'(req_ready[k]), 64'd1);
   endtask

   // One full transaction with model-predicted response and latency.
   task automatic run(int k, logic [1:0] op, logic [63:0] a, logic [63:0] wd, int hold, string tag);
      logic        e_err;
      logic [63:0] e_data;
      int          cyc;
      logic        rv;
      e_err  = exp_err(op, a);
      e_data = '0;
      if (!e_err && op == 2'b00) e_data = mdl_rd(k, a, 4);
      if (!e_err && op == 2'b01) e_data = mdl_rd(k, a, 8);

      wait_ready(k, tag);
      req_valid[k] = 1'b1;
      req_op[k]    = op;
      req_addr[k]  = a;
      req_wdata[k] = wd;
      @(posedge clk);
      #1;
      // Garbage on the request bus while busy must be ignored.
      req_op[k]    = 2'($urandom);
      req_addr[k]  = {$urandom, $urandom};
      req_wdata[k] = {$urandom, $urandom};
      cyc = 0;
      rv  = 1'b0;
      while (!rv && cyc < 40) begin
         @(posedge clk);
         #1;
         cyc++;
         rv = rsp_valid[k];
      end
      req_valid[k] = 1'b0;
      chk({tag, ":lat"}, 64'(cyc), 64'(lat_of(k)));
      chk({tag, ":data"}, rsp_data[k], e_data);
      chk({tag, ":err"}, 64'(rsp_err[k]), 64'(e_err));

      for (int h = 0; h < hold; h++) begin
         @(negedge clk);
         chk({tag, ":hold_v"}, 64'(rsp_valid[k]), 64'd1);
         chk({tag, ":hold_d"}, rsp_data[k], e_data);
         chk({tag, ":hold_rdy"}, 64'(req_ready[k]), 64'd0);
      end
      rsp_ready[k] = 1'b1;
      @(posedge clk);
      #1;
      rsp_ready[k] = 1'b0;
      chk({tag, ":done_v"}, 64'(rsp_valid[k]), 64'd0);
      chk({tag, ":done_rdy"}, 64'(req_ready[k]), 64'd1);

      if (!e_err && op == 2'b10) begin
         for (int i = 0; i < 8; i++) mdl[key(k, a + 64'(i))] = wd[8*i +: 8];
      end
   endtask

   task automatic random_phase(int k, int n);
      logic [1:0]  op;
      logic [63:0] a;
      int          sel;
      for (int i = 0; i < 32; i++) begin
         run(k, 2'b10, RB + 64'(8 * i), {$urandom, $urandom}, 0, "pre");
      end
      for (int i = 0; i < n; i++) begin
         op  = 2'($urandom_range(0, 3));
         sel = $urandom_range(0, 9);
         if (sel < 8)       a = RB + 64'($urandom_range(0, 247));
         else if (sel == 8) a = MEMB - 64'($urandom_range(1, 3));
         else               a = 64'hFFFF_FFFF_FFFF_FFFF - 64'($urandom_range(0, 6));
         run(k, op, a, {$urandom, $urandom}, $urandom_range(0, 2), "rnd");
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog obs=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      for (int k = 0; k < NI; k++) begin
         rst_n[k]     = 1'b0;
         req_valid[k] = 1'b0;
         req_op[k]    = '0;
         req_addr[k]  = '0;
         req_wdata[k] = '0;
         rsp_ready[k] = 1'b0;
      end
      repeat (3) @(negedge clk);
      for (int k = 0; k < NI; k++) begin
         chk("rst_rdy",  64'(req_ready[k]), 64'd0);
         chk("rst_v",    64'(rsp_valid[k]), 64'd0);
         chk("rst_data", rsp_data[k], 64'd0);
         chk("rst_err",  64'(rsp_err[k]), 64'd0);
         rst_n[k] = 1'b1;
      end

      // Store, read back, fetch upper half.
      run(0, 2'b10, 64'h2000, 64'h1122334455667788, 0, "t1_st");
      run(0, 2'b01, 64'h2000, 64'h0, 0, "t1_ld");
      run(0, 2'b00, 64'h2004, 64'h0, 0, "t1_fe");
      // Response held five cycles with rsp_ready low.
      run(0, 2'b01, 64'h2000, 64'h0, 5, "t2_hold");
      // Range boundary.
      run(0, 2'b10, MEMB - 8, 64'hA5A5_5A5A_0F0F_F0F0, 0, "t3_pre");
      run(0, 2'b01, MEMB - 4, 64'h0, 0, "t3_ld");
      run(0, 2'b10, MEMB - 4, 64'hDEAD_BEEF_DEAD_BEEF, 0, "t3_st");
      run(0, 2'b01, MEMB - 8, 64'h0, 0, "t3_chk");
      run(0, 2'b00, MEMB - 4, 64'h0, 0, "t3_fe_last");
      run(0, 2'b01, 64'hFFFF_FFFF_FFFF_FFFC, 64'h0, 0, "t3_wrap");
      // Unaligned load across two words.
      run(0, 2'b10, 64'h2008, 64'h99AA_BBCC_DDEE_FF00, 0, "t5_pre");
      run(0, 2'b01, 64'h2003, 64'h0, 0, "t5_ld");

      // Reset during a pending store cancels it.
      run(2, 2'b10, 64'h3000, 64'h0123_4567_89AB_CDEF, 0, "t4_pre");
      wait_ready(2, "t4_acc");
      req_valid[2] = 1'b1;
      req_op[2]    = 2'b10;
      req_addr[2]  = 64'h3000;
      req_wdata[2] = 64'hFFFF_FFFF_FFFF_FFFF;
      @(posedge clk);
      #1;
      req_valid[2] = 1'b0;
      @(posedge clk);
      #1;
      rst_n[2] = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("t4_rst_v",   64'(rsp_valid[2]), 64'd0);
         chk("t4_rst_rdy", 64'(req_ready[2]), 64'd0);
      end
      rst_n[2] = 1'b1;
      run(2, 2'b01, 64'h3000, 64'h0, 0, "t4_ld");

      // Reserved op on the extreme latencies.
      run(1, 2'b11, 64'h100, 64'h0, 0, "t6_rsvd1");
      run(3, 2'b11, 64'h100, 64'h0, 0, "t6_rsvd15");

      for (int k = 0; k < NI; k++) random_phase(k, 40);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
